// File: rtl/dram_bank_timer_if.sv
// Command/status bundle between the scheduler and one bank's timing tracker.
// The scheduler drives commands; the tracker reports legality and row state.
interface dram_bank_timer_if #(
  parameter int ROW_W = 14
);
  logic             act_i;
  logic             rd_i;
  logic             wr_i;
  logic             pre_i;
  logic [ROW_W-1:0] row_i;
  logic             row_open_o;
  logic [ROW_W-1:0] open_row_o;
  logic             act_ready_o;
  logic             rdwr_ready_o;
  logic             pre_ready_o;
  logic             cmd_err_o;

  modport master (
    output act_i, rd_i, wr_i, pre_i, row_i,
    input  row_open_o, open_row_o, act_ready_o, rdwr_ready_o, pre_ready_o, cmd_err_o
  );

  modport slave (
    input  act_i, rd_i, wr_i, pre_i, row_i,
    output row_open_o, open_row_o, act_ready_o, rdwr_ready_o, pre_ready_o, cmd_err_o
  );
endinterface

// File: rtl/dram_bank_timer.sv
// Per-bank DRAM timing tracker: bank state, open row, and tRCD/tRAS/tRP/tRTP/tWR
// down-counters that gate which commands the scheduler may legally issue.
module dram_bank_timer #(
  parameter int ROW_W = 14,
  parameter int CNT_W = 4,
  parameter int T_RCD = 4,
  parameter int T_RAS = 10,
  parameter int T_RP  = 4,
  parameter int T_RTP = 2,
  parameter int T_WR  = 6
) (
  input  logic               CLK,
  input  logic               RST,
  dram_bank_timer_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_CLOSED      = 2'd0,
    ST_ACTIVATING  = 2'd1,
    ST_OPEN        = 2'd2,
    ST_PRECHARGING = 2'd3
  } state_t;

  // Counters are loaded with T-1 so that a command in cycle n releases cycle n+T.
  localparam logic [CNT_W-1:0] RCD_LD = CNT_W'(T_RCD - 1);
  localparam logic [CNT_W-1:0] RAS_LD = CNT_W'(T_RAS - 1);
  localparam logic [CNT_W-1:0] RP_LD  = CNT_W'(T_RP - 1);
  localparam logic [CNT_W-1:0] RTP_LD = CNT_W'(T_RTP - 1);
  localparam logic [CNT_W-1:0] WR_LD  = CNT_W'(T_WR - 1);

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   t_cnt_reg, t_cnt_next;
  logic [CNT_W-1:0]   ras_cnt_reg, ras_cnt_next;
  logic [CNT_W-1:0]   pre_cnt_reg, pre_cnt_next;
  logic [ROW_W-1:0]   open_row_reg, open_row_next;
  logic               err_reg, err_next;

  logic [CNT_W-1:0]   t_dec, ras_dec, pre_dec;
  logic               row_open, act_ready, rdwr_ready, pre_ready;
  logic               multi_cmd, act_ok, rd_ok, wr_ok, pre_ok, reject;

  function automatic logic [CNT_W-1:0] dec_sat(input logic [CNT_W-1:0] v);
    return (v == '0) ? '0 : v - 1'b1;
  endfunction

  function automatic logic [CNT_W-1:0] max_cnt(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

  assign t_dec   = dec_sat(t_cnt_reg);
  assign ras_dec = dec_sat(ras_cnt_reg);
  assign pre_dec = dec_sat(pre_cnt_reg);

  // Any pair of simultaneous commands is illegal regardless of readiness.
  assign multi_cmd = (bus.act_i & bus.rd_i)  | (bus.act_i & bus.wr_i) |
                     (bus.act_i & bus.pre_i) | (bus.rd_i  & bus.wr_i) |
                     (bus.rd_i  & bus.pre_i) | (bus.wr_i  & bus.pre_i);

  assign act_ok = bus.act_i & ~multi_cmd & act_ready;
  assign rd_ok  = bus.rd_i  & ~multi_cmd & rdwr_ready;
  assign wr_ok  = bus.wr_i  & ~multi_cmd & rdwr_ready;
  assign pre_ok = bus.pre_i & ~multi_cmd & pre_ready;
  assign reject = multi_cmd |
                  (bus.act_i & ~act_ready)  | (bus.rd_i  & ~rdwr_ready) |
                  (bus.wr_i  & ~rdwr_ready) | (bus.pre_i & ~pre_ready);

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg    <= ST_CLOSED;
      t_cnt_reg    <= '0;
      ras_cnt_reg  <= '0;
      pre_cnt_reg  <= '0;
      open_row_reg <= '0;
      err_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      t_cnt_reg    <= t_cnt_next;
      ras_cnt_reg  <= ras_cnt_next;
      pre_cnt_reg  <= pre_cnt_next;
      open_row_reg <= open_row_next;
      err_reg      <= err_next;
    end
  end

  // Next-state and counter logic.
  always_comb begin
    state_next    = state_reg;
    t_cnt_next    = t_dec;
    ras_cnt_next  = ras_dec;
    pre_cnt_next  = pre_dec;
    open_row_next = open_row_reg;
    err_next      = reject;

    case (state_reg)
      ST_CLOSED: begin
        if (act_ok) begin
          state_next = (T_RCD <= 1) ? ST_OPEN : ST_ACTIVATING;
        end
      end
      ST_ACTIVATING: begin
        if (t_dec == '0) begin
          state_next = ST_OPEN;
        end
      end
      ST_OPEN: begin
        if (pre_ok) begin
          state_next = (T_RP <= 1) ? ST_CLOSED : ST_PRECHARGING;
        end
      end
      ST_PRECHARGING: begin
        if (t_dec == '0) begin
          state_next = ST_CLOSED;
        end
      end
      default: state_next = ST_CLOSED;
    endcase

    if (act_ok) begin
      t_cnt_next    = RCD_LD;
      ras_cnt_next  = RAS_LD;
      open_row_next = bus.row_i;
    end
    if (pre_ok) begin
      t_cnt_next = RP_LD;
    end
    // A short read recovery must never cut a pending write recovery.
    if (rd_ok) begin
      pre_cnt_next = max_cnt(pre_dec, RTP_LD);
    end
    if (wr_ok) begin
      pre_cnt_next = max_cnt(pre_dec, WR_LD);
    end
  end

  // Output decode from registered state only.
  always_comb begin
    row_open   = (state_reg == ST_ACTIVATING) || (state_reg == ST_OPEN);
    act_ready  = (state_reg == ST_CLOSED);
    rdwr_ready = (state_reg == ST_OPEN);
    pre_ready  = (state_reg == ST_OPEN) && (ras_cnt_reg == '0) && (pre_cnt_reg == '0);
  end

  assign bus.row_open_o   = row_open;
  assign bus.open_row_o   = open_row_reg;
  assign bus.act_ready_o  = act_ready;
  assign bus.rdwr_ready_o = rdwr_ready;
  assign bus.pre_ready_o  = pre_ready;
  assign bus.cmd_err_o    = err_reg;

endmodule

// File: tb/tb_dram_bank_timer.sv
// Directed bench for dram_bank_timer: a cycle-time model of the bank rules is
// compared every cycle, plus literal expectations taken from hand-worked timelines.
module tb_dram_bank_timer;
  localparam int ROW_W = 14;
  localparam int T_RCD = 4;
  localparam int T_RAS = 10;
  localparam int T_RP  = 4;
  localparam int T_RTP = 2;
  localparam int T_WR  = 6;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  dram_bank_timer_if #(.ROW_W(ROW_W)) bus ();

  dram_bank_timer #(
    .ROW_W(ROW_W), .CNT_W(4), .T_RCD(T_RCD), .T_RAS(T_RAS),
    .T_RP(T_RP), .T_RTP(T_RTP), .T_WR(T_WR)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // Model: bank described by the cycle numbers of the last accepted commands.
  logic             m_open;
  logic [ROW_W-1:0] m_row;
  logic             m_err;
  int               m_last_act, m_last_pre, m_pre_allowed;

  function automatic logic m_rdwr_rdy(input int c);
    return m_open && (c >= m_last_act + T_RCD);
  endfunction
  function automatic logic m_pre_rdy(input int c);
    return m_rdwr_rdy(c) && (c >= m_last_act + T_RAS) && (c >= m_pre_allowed);
  endfunction
  function automatic logic m_act_rdy(input int c);
    return !m_open && (c >= m_last_pre + T_RP);
  endfunction

  task automatic model_reset();
    m_open = 1'b0; m_row = '0; m_err = 1'b0;
    m_last_act = -1000; m_last_pre = -1000; m_pre_allowed = -1000;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge CLK or posedge RST);
      if (RST) begin
        model_reset();
      end else begin
        int c, n;
        logic rej;
        c = cyc;
        n = int'(bus.act_i) + int'(bus.rd_i) + int'(bus.wr_i) + int'(bus.pre_i);
        rej = 1'b0;
        if (n >= 2) begin
          rej = 1'b1;
        end else if (bus.act_i) begin
          if (m_act_rdy(c)) begin
            m_open = 1'b1; m_last_act = c; m_row = bus.row_i;
          end else rej = 1'b1;
        end else if (bus.rd_i || bus.wr_i) begin
          if (m_rdwr_rdy(c)) begin
            int t;
            t = c + (bus.wr_i ? T_WR : T_RTP);
            if (t > m_pre_allowed) m_pre_allowed = t;
          end else rej = 1'b1;
        end else if (bus.pre_i) begin
          if (m_pre_rdy(c)) begin
            m_open = 1'b0; m_last_pre = c;
          end else rej = 1'b1;
        end
        m_err = rej;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=0x%0h expected=0x%0h", name, cyc, got, exp);
    end
  endtask

  // Per-cycle comparison against the model, mid-cycle.
  initial begin
    forever begin
      @(negedge CLK);
      #1;
      if (!RST) begin
        chk("m_row_open",   32'(bus.row_open_o),   32'(m_open));
        chk("m_open_row",   32'(bus.open_row_o),   32'(m_row));
        chk("m_act_ready",  32'(bus.act_ready_o),  32'(m_act_rdy(cyc)));
        chk("m_rdwr_ready", 32'(bus.rdwr_ready_o), 32'(m_rdwr_rdy(cyc)));
        chk("m_pre_ready",  32'(bus.pre_ready_o),  32'(m_pre_rdy(cyc)));
        chk("m_cmd_err",    32'(bus.cmd_err_o),    32'(m_err));
      end
    end
  end

  task automatic drive(input logic a, input logic r, input logic w, input logic p,
                       input logic [ROW_W-1:0] row);
    bus.act_i = a; bus.rd_i = r; bus.wr_i = w; bus.pre_i = p; bus.row_i = row;
    @(negedge CLK);
    bus.act_i = 1'b0; bus.rd_i = 1'b0; bus.wr_i = 1'b0; bus.pre_i = 1'b0;
    $display("cycle %0d: act=%0b rd=%0b wr=%0b pre=%0b row=0x%0h -> row_open=%0b act_rdy=%0b rdwr_rdy=%0b pre_rdy=%0b err=%0b",
             cyc - 1, a, r, w, p, row, bus.row_open_o, bus.act_ready_o,
             bus.rdwr_ready_o, bus.pre_ready_o, bus.cmd_err_o);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  initial begin
    bus.act_i = 1'b0; bus.rd_i = 1'b0; bus.wr_i = 1'b0; bus.pre_i = 1'b0; bus.row_i = '0;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    #1;
    chk("rst_act_ready",  32'(bus.act_ready_o),  32'd1);
    chk("rst_rdwr_ready", 32'(bus.rdwr_ready_o), 32'd0);
    chk("rst_pre_ready",  32'(bus.pre_ready_o),  32'd0);
    chk("rst_open_row",   32'(bus.open_row_o),   32'd0);

    // ACT 0x1A5 at cycle 0, RD at 4, rejected PRE at 9, PRE at 10.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 14'h1A5);          // now cycle 1
    chk("t1_open_row",  32'(bus.open_row_o),   32'h1A5);
    chk("t1_row_open",  32'(bus.row_open_o),   32'd1);
    chk("t1_rdwr_c1",   32'(bus.rdwr_ready_o), 32'd0);
    idle(2);                                         // cycle 3
    chk("t1_rdwr_c3",   32'(bus.rdwr_ready_o), 32'd0);
    idle(1);                                         // cycle 4
    chk("t1_rdwr_c4",   32'(bus.rdwr_ready_o), 32'd1);
    drive(1'b0, 1'b1, 1'b0, 1'b0, '0);               // RD at 4, now cycle 5
    chk("t1_rd_err",    32'(bus.cmd_err_o),    32'd0);
    idle(4);                                         // cycle 9
    chk("t1_pre_rdy_c9", 32'(bus.pre_ready_o), 32'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, '0);               // PRE at 9, now cycle 10
    chk("t1_pre9_err",  32'(bus.cmd_err_o),    32'd1);
    chk("t1_still_open", 32'(bus.rdwr_ready_o), 32'd1);
    chk("t1_pre_rdy_c10", 32'(bus.pre_ready_o), 32'd1);
    drive(1'b0, 1'b0, 1'b0, 1'b1, '0);               // PRE at 10, now cycle 11
    chk("t1_act_c11",   32'(bus.act_ready_o),  32'd0);
    chk("t1_closed_row", 32'(bus.row_open_o),  32'd0);
    idle(2);                                         // cycle 13
    chk("t1_act_c13",   32'(bus.act_ready_o),  32'd0);
    idle(1);                                         // cycle 14
    chk("t1_act_c14",   32'(bus.act_ready_o),  32'd1);
    chk("t1_row_kept",  32'(bus.open_row_o),   32'h1A5);

    // ACT 0x0F0 at 0, WR at 5, RD at 6: write recovery gates PRE until 11.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 14'h0F0);          // cycle 1
    idle(4);                                         // cycle 5
    drive(1'b0, 1'b0, 1'b1, 1'b0, '0);               // WR at 5
    drive(1'b0, 1'b1, 1'b0, 1'b0, '0);               // RD at 6, now cycle 7
    chk("t2_rd_err",    32'(bus.cmd_err_o),    32'd0);
    idle(3);                                         // cycle 10
    chk("t2_pre_c10",   32'(bus.pre_ready_o),  32'd0);
    idle(1);                                         // cycle 11
    chk("t2_pre_c11",   32'(bus.pre_ready_o),  32'd1);
    drive(1'b0, 1'b0, 1'b0, 1'b1, '0);
    idle(3);
    chk("t2_closed",    32'(bus.act_ready_o),  32'd1);

    // Simultaneous ACT+RD, then a lone RD while closed: back-to-back errors.
    drive(1'b1, 1'b1, 1'b0, 1'b0, 14'h3FF);
    chk("t3_multi_err", 32'(bus.cmd_err_o),    32'd1);
    chk("t3_act_rdy",   32'(bus.act_ready_o),  32'd1);
    chk("t3_row_same",  32'(bus.open_row_o),   32'h0F0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, '0);
    chk("t3_rd_err",    32'(bus.cmd_err_o),    32'd1);
    chk("t3_rd_closed", 32'(bus.row_open_o),   32'd0);
    idle(1);
    chk("t3_err_clear", 32'(bus.cmd_err_o),    32'd0);

    // Asynchronous reset in the middle of ACTIVATING, then an immediate ACT.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 14'h055);
    idle(1);                                         // cycle 2
    #2 RST = 1'b1;
    #1;
    chk("t4_rst_row_open", 32'(bus.row_open_o),  32'd0);
    chk("t4_rst_open_row", 32'(bus.open_row_o),  32'd0);
    chk("t4_rst_act_rdy",  32'(bus.act_ready_o), 32'd1);
    chk("t4_rst_err",      32'(bus.cmd_err_o),   32'd0);
    @(negedge CLK);
    RST = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 14'h02A);
    chk("t4_act_ok",    32'(bus.row_open_o),   32'd1);
    chk("t4_act_row",   32'(bus.open_row_o),   32'h02A);
    chk("t4_act_err",   32'(bus.cmd_err_o),    32'd0);
    idle(12);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dram_bank_timer.md
Name: dram_bank_timer

Overview:
Per-bank DRAM command-timing tracker for the STEP2 controller. It sits directly upstream of the command issue mux and gates which commands the scheduler may issue to one bank. It tracks bank state and the open row, and enforces tRCD, tRAS, tRP, tRTP and tWR with down-counters. The RTL is structural/RTL-mixed and must map cleanly onto the team's simple cell set (inverters, 2/3-input gates, MUX21, DFF).

Parameters:
ROW_W, 14, row address width
CNT_W, 4, timing counter width; every T_* must be <= 2**CNT_W-1
T_RCD, 4, cycles from ACT to the first legal RD/WR (>=1)
T_RAS, 10, cycles from ACT to the first legal PRE (must be >= T_RCD)
T_RP, 4, cycles from PRE to the next legal ACT (>=1)
T_RTP, 2, cycles from RD to the first legal PRE (>=1)
T_WR, 6, cycles from WR to the first legal PRE (>=1)

Ports:
CLK  in  1  clock, rising edge
RST  in  1  asynchronous reset, active-high
act_i  in  1  ACT command issued this cycle
rd_i  in  1  RD command issued this cycle
wr_i  in  1  WR command issued this cycle
pre_i  in  1  PRE command issued this cycle
row_i  in  ROW_W  row address; sampled with act_i
row_open_o  out  1  bank holds an open row (ACTIVATING or OPEN)
open_row_o  out  ROW_W  row latched by the last accepted ACT
act_ready_o  out  1  ACT is legal this cycle
rdwr_ready_o  out  1  RD/WR is legal this cycle
pre_ready_o  out  1  PRE is legal this cycle
cmd_err_o  out  1  one-cycle pulse: previous cycle's command was rejected

Behaviour:
- Reset is asynchronous, active-high, and may occur at any time, including mid-operation. On reset: state=CLOSED, all counters=0, open_row_o=0, row_open_o=0, act_ready_o=1, rdwr_ready_o=0, pre_ready_o=0, cmd_err_o=0.
- Clock and reset naming: one clock, CLK; asynchronous active-high reset, RST.
- A command is "issued in cycle n" when its input is high at the rising edge ending cycle n. All outputs are functions of registered state only; there is no combinational path from any *_i input to any output.
- States and transitions:
  - CLOSED -> ACTIVATING on an accepted ACT. The ACT load is a counter that expires T_RCD cycles later.
  - ACTIVATING -> OPEN when the tRCD counter expires.
  - OPEN -> PRECHARGING on an accepted PRE.
  - PRECHARGING -> CLOSED when the tRP counter expires.
- Ready rules:
  - ACT in cycle n: rdwr_ready_o=1 from cycle n+T_RCD.
  - pre_ready_o=1 only when all of these hold: state is OPEN, at least T_RAS cycles since the ACT, and the pre-delay counter is 0.
  - PRE in cycle n: act_ready_o=1 from cycle n+T_RP.
  - act_ready_o=1 only in CLOSED. rdwr_ready_o=1 only in OPEN.
- Pre-delay counter:
  - An RD in cycle n loads max(remaining, T_RTP).
  - A WR in cycle n loads max(remaining, T_WR).
  - The counter decrements to 0 and saturates there. A later short RD must never shorten a pending write recovery.
- tRAS counter: loaded on ACT; runs through ACTIVATING and OPEN; saturates at 0.
- open_row_o latches row_i on an accepted ACT and holds until the next accepted ACT. It is not cleared on PRE.
- Rejection:
  - A command is rejected if two or more of act_i/rd_i/wr_i/pre_i are high in the same cycle.
  - A command is also rejected if its ready output is low in the cycle it is issued.
  - A rejected command has no effect on state, counters or open_row_o.
  - cmd_err_o pulses high in cycle n+1 for a rejection in cycle n.
  - Back-to-back rejections give back-to-back pulses.
- Counters never wrap. Each counter saturates at 0.

Test Plan:
- Defaults, ACT row=0x1A5 in cycle 0 -> open_row_o=0x1A5 and row_open_o=1 from cycle 1; rdwr_ready_o=0 in cycles 1-3 and 1 in cycle 4; RD in cycle 4 is accepted with cmd_err_o=0.
- After ACT in cycle 0, PRE in cycle 9 -> cmd_err_o=1 in cycle 10 and state stays OPEN; PRE in cycle 10 is accepted; act_ready_o=0 in cycles 11-13 and 1 in cycle 14.
- ACT in cycle 0, WR in cycle 5, RD in cycle 6 -> pre_ready_o stays 0 until cycle 11 (WR recovery dominates tRTP) and is 1 in cycle 11.
- ACT and RD both high in the same cycle from CLOSED -> cmd_err_o pulses next cycle, state stays CLOSED, act_ready_o=1, open_row_o unchanged.
- RST asserted asynchronously mid-ACTIVATING (cycle 2) -> all outputs go to reset values immediately; after release, ACT is accepted at once.
- RD issued while CLOSED -> cmd_err_o=1 for exactly one cycle; all counters unchanged.
